// File: rtl/gate_bist_pkg.sv
// Shared types, constants and the reference gate function for the gate
// block self-test engine.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  localparam int NOT_A_BIT = 6;
  localparam int OR_BIT    = 5;
  localparam int AND_BIT   = 4;
  localparam int NOR_BIT   = 3;
  localparam int NAND_BIT  = 2;
  localparam int XOR_BIT   = 1;
  localparam int XNOR_BIT  = 0;

  // Expected gate outputs for stimulus v (v[1] = A, v[0] = B).
  function automatic logic [6:0] expected_gates(input logic [1:0] v);
    logic       a;
    logic       b;
    logic [6:0] e;
    a = v[1];
    b = v[0];
    e = 7'd0;
    e[NOT_A_BIT] = ~a;
    e[OR_BIT]    = a | b;
    e[AND_BIT]   = a & b;
    e[NOR_BIT]   = ~(a | b);
    e[NAND_BIT]  = ~(a & b);
    e[XOR_BIT]   = a ^ b;
    e[XNOR_BIT]  = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational golden model of the seven-output gate block.
module gate_golden_model
  import gate_bist_pkg::*;
(
  input  logic [1:0] i_entrada,
  output logic [6:0] o_expected
);

  assign o_expected = expected_gates(i_entrada);

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test engine: sweeps entrada through all four vectors, waits a settle
// time, compares the gate outputs against the golden model and logs results.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [1:0] entrada,
  input  logic       NOT_A,
  input  logic       OR,
  input  logic       AND,
  input  logic       NOR,
  input  logic       NAND,
  input  logic       XOR,
  input  logic       XNOR,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec,
  output logic [6:0] fail_mask
);

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_VEC   = 2'(NUM_VECTORS - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_entrada;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err_count;
  logic [1:0] r_fail_vec;
  logic [6:0] r_fail_mask;

  logic [6:0] w_expected;
  logic [6:0] w_observed;
  logic [6:0] w_diff;
  logic       w_mismatch;
  logic [2:0] w_err_next;

  gate_golden_model u_golden (
    .i_entrada  (r_entrada),
    .o_expected (w_expected)
  );

  assign w_observed = {NOT_A, OR, AND, NOR, NAND, XOR, XNOR};
  assign w_diff     = w_expected ^ w_observed;
  assign w_mismatch = (w_diff != 7'd0);

  // At most four failures fit in three bits, so the count cannot wrap.
  always_comb begin
    w_err_next = r_err_count;
    if (w_mismatch) begin
      w_err_next = r_err_count + 3'd1;
    end else begin
      w_err_next = r_err_count;
    end
  end

  // Sweep sequencer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_entrada   <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= 2'd0;
      r_fail_mask <= 7'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= SETTLE;
            r_entrada   <= 2'd0;
            r_cnt       <= CNT_RELOAD;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_vec  <= 2'd0;
            r_fail_mask <= 7'd0;
          end
        end
        SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        CHECK: begin
          r_err_count <= w_err_next;
          if (w_mismatch && (r_err_count == 3'd0)) begin
            r_fail_vec  <= r_entrada;
            r_fail_mask <= w_diff;
          end
          if (r_entrada == LAST_VEC) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 3'd0);
          end else begin
            r_state   <= SETTLE;
            r_entrada <= r_entrada + 2'd1;
            r_cnt     <= CNT_RELOAD;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign entrada   = r_entrada;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;
  assign fail_mask = r_fail_mask;

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Synthesizable self-test engine for the seven-output two-input gate block.
- Drives the 2-bit `entrada` bus through all four input combinations.
- Waits a programmable settle time after each new vector, then samples the seven gate outputs and compares them against a golden model.
- Reports pass/fail, the failing-vector count and a snapshot of the first failure. Sits beside the gate block on the board, in place of a simulation bench.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after each new `entrada` before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep.
- entrada  output  2  stimulus to the gate block; bit1 = A, bit0 = B.
- NOT_A  input  1  gate output, expected ~A.
- OR  input  1  gate output, expected A|B.
- AND  input  1  gate output, expected A&B.
- NOR  input  1  gate output, expected ~(A|B).
- NAND  input  1  gate output, expected ~(A&B).
- XOR  input  1  gate output, expected A^B.
- XNOR  input  1  gate output, expected ~(A^B).
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid while done; 1 when err_count == 0.
- err_count  output  3  number of failing vectors, 0..4.
- fail_vec  output  2  `entrada` value of the first failing vector.
- fail_mask  output  7  expected XOR observed for the first failing vector. Bit order is {NOT_A,OR,AND,NOR,NAND,XOR,XNOR}, bit6..bit0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; entrada=0; busy=0; done=0; pass=0; err_count=0; fail_vec=0; fail_mask=0; settle counter=0.
  - Reset asserted mid-sweep aborts the sweep immediately; no partial results are retained.
- States:
  - IDLE → SETTLE on start=1. At that edge: entrada←0; cnt←SETTLE_CYCLES-1; err_count, fail_vec, fail_mask, done, pass cleared; busy←1.
  - SETTLE: cnt decrements each cycle. When cnt==0, next state is CHECK.
  - CHECK (one cycle): observed outputs are compared combinationally with the golden model for the current entrada.
    - On mismatch: err_count increments. If err_count was 0, fail_vec←entrada and fail_mask←diff.
    - If entrada==3: next state DONE. Otherwise entrada increments, cnt reloads to SETTLE_CYCLES-1, next state SETTLE.
  - DONE: busy=0; done=1; pass=(err_count==0).
    - entrada holds 3.
    - start=1 in DONE behaves exactly as in IDLE: clear results and restart.
- start is ignored while busy.
- Latency: done rises 4*(SETTLE_CYCLES+1) clocks after the edge that accepted start; 12 clocks at the default.
- entrada changes only on the CHECK→SETTLE transition and on start acceptance. It is stable throughout every SETTLE and CHECK cycle.
- err_count saturates naturally at 4; no wrap is possible with a 3-bit field.
- Gate inputs are sampled only in CHECK; values in other states have no effect.
- All outputs are registered.

Decomposition:
- Package gate_bist_pkg holds:
  - state enum {IDLE, SETTLE, CHECK, DONE};
  - localparam NUM_VECTORS=4;
  - mask bit-index constants (NOT_A_BIT=6 … XNOR_BIT=0);
  - function expected_gates(logic [1:0] v) returning the 7-bit expected vector.
- One combinational sub-module, gate_golden_model: entrada in, 7-bit expected out. It is reusable by benches as the scoreboard.

Test Plan:
- Golden gate block attached, start pulse → done after 12 clocks; pass=1, err_count=0, fail_mask=0; entrada sequence 0,1,2,3, each value held 3 clocks.
- XOR output forced to 0 → fails at vectors 1 and 2; err_count=2, fail_vec=1, fail_mask=7'b0000010, pass=0.
- NOT_A inverted (wired to A) → all 4 vectors fail; err_count=4, fail_vec=0, fail_mask=7'b1000000.
- start pulsed again at clock 5 of a sweep → ignored, done still at clock 12. Then start in DONE → results cleared on the next edge, second sweep completes with identical results.
- rst_n pulled low asynchronously mid-SETTLE of vector 2 → all outputs return to reset values immediately; a new start then runs a full clean sweep.
- SETTLE_CYCLES=1 build → done 8 clocks after start; SETTLE_CYCLES=15 → 64 clocks; results match the default build.
